// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stall/flush control: FSM states and the
// stall/flush bundle reused by the datapath top.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    MD_WAIT
  } ctrl_state_t;

  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
  } pipe_ctrl_t;

  // Whole pipe frozen behind a pending data-memory access; W gets a bubble.
  function automatic pipe_ctrl_t mem_hold();
    pipe_ctrl_t c;
    c = '0;
    c.stall_f = 1'b1;
    c.stall_d = 1'b1;
    c.stall_e = 1'b1;
    c.stall_m = 1'b1;
    c.flush_w = 1'b1;
    return c;
  endfunction

  // F/D/E frozen behind a busy mul/div; M gets a bubble.
  function automatic pipe_ctrl_t md_hold();
    pipe_ctrl_t c;
    c = '0;
    c.stall_f = 1'b1;
    c.stall_d = 1'b1;
    c.stall_e = 1'b1;
    c.flush_m = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: load-use and branch hazards plus a FSM that freezes
// the pipe during multi-cycle memory and mul/div operations.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic                  MemReadE,
  input  logic                  PCSrcE,
  input  logic                  MdStartE,
  input  logic                  MdDoneE,
  input  logic                  MemReqM,
  input  logic                  MemAckM,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  FlushW,
  output logic                  MemErr,
  output logic [CNT_W-1:0]      StallCnt,
  output logic [CNT_W-1:0]      FlushCnt
);

  // Wide enough to hold MEM_TIMEOUT without overflow.
  localparam int unsigned TW = $clog2(MEM_TIMEOUT + 2);
  localparam logic [TW-1:0] TimeoutVal = TW'(MEM_TIMEOUT);

  ctrl_state_t   state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
  logic          err_q, err_d;
  logic          lu, mem_block;
  pipe_ctrl_t    ctrl, ctrl_run;

  assign lu = MemReadE && (RdE != REG_ADDR_W'(REG_ZERO)) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_block = MemReqM && !MemAckM;
  assign tmo_inc = tmo_q + TW'(1);

  // Branch/load-use resolution, shared by RUN and the mul/div completion cycle.
  always_comb begin
    ctrl_run = '0;
    if (PCSrcE) begin
      ctrl_run.flush_d = 1'b1;
      ctrl_run.flush_e = 1'b1;
    end else if (lu) begin
      ctrl_run.stall_f = 1'b1;
      ctrl_run.stall_d = 1'b1;
      ctrl_run.flush_e = 1'b1;
    end
  end

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    unique case (state_q)
      RUN: begin
        if (mem_block) begin
          ctrl    = mem_hold();
          state_d = MEM_WAIT;
          tmo_d   = TW'(1);
        end else if (MdStartE && !MdDoneE) begin
          ctrl    = md_hold();
          state_d = MD_WAIT;
        end else begin
          ctrl = ctrl_run;
        end
      end
      MEM_WAIT: begin
        if (MemAckM) begin
          state_d = RUN;
          tmo_d   = '0;
        end else if (tmo_inc >= TimeoutVal) begin
          ctrl.flush_m = 1'b1;
          err_d        = 1'b1;
          state_d      = RUN;
          tmo_d        = '0;
        end else begin
          ctrl  = mem_hold();
          tmo_d = tmo_inc;
        end
      end
      MD_WAIT: begin
        if (mem_block) begin
          ctrl = mem_hold();
        end else if (MdDoneE) begin
          ctrl    = ctrl_run;
          state_d = RUN;
        end else begin
          ctrl = md_hold();
        end
      end
      default: begin
        state_d = RUN;
        tmo_d   = '0;
      end
    endcase
    if (rst) begin
      ctrl = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign StallF = ctrl.stall_f;
  assign StallD = ctrl.stall_d;
  assign StallE = ctrl.stall_e;
  assign StallM = ctrl.stall_m;
  assign FlushD = ctrl.flush_d;
  assign FlushE = ctrl.flush_e;
  assign FlushM = ctrl.flush_m;
  assign FlushW = ctrl.flush_w;
  assign MemErr = err_q;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(ctrl.stall_f),
    .cnt(StallCnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk(clk),
    .rst(rst),
    .inc(ctrl.flush_d | ctrl.flush_e),
    .cnt(FlushCnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios then random traffic,
// checked against a cycle-level behavioural model.
module tb_pipeline_ctrl;

  localparam int unsigned RW  = 5;
  localparam int unsigned CW  = 4;
  localparam int unsigned TMO = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RW-1:0] Rs1D = '0, Rs2D = '0, RdE = '0;
  logic          MemReadE = 1'b0, PCSrcE = 1'b0, MdStartE = 1'b0, MdDoneE = 1'b0;
  logic          MemReqM = 1'b0, MemAckM = 1'b0;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MemErr;
  logic [CW-1:0] StallCnt, FlushCnt;

  pipeline_ctrl #(
    .REG_ADDR_W (RW),
    .CNT_W      (CW),
    .MEM_TIMEOUT(TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .Rs1D    (Rs1D),
    .Rs2D    (Rs2D),
    .RdE     (RdE),
    .MemReadE(MemReadE),
    .PCSrcE  (PCSrcE),
    .MdStartE(MdStartE),
    .MdDoneE (MdDoneE),
    .MemReqM (MemReqM),
    .MemAckM (MemAckM),
    .StallF  (StallF),
    .StallD  (StallD),
    .StallE  (StallE),
    .StallM  (StallM),
    .FlushD  (FlushD),
    .FlushE  (FlushE),
    .FlushM  (FlushM),
    .FlushW  (FlushW),
    .MemErr  (MemErr),
    .StallCnt(StallCnt),
    .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit [7:0] ctrl;  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW}
    bit       chk_regs;
    bit       err;
    int       sc;
    int       fc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Model: how many cycles the pending memory access has already stalled
  // (0 = none), whether a mul/div is outstanding, sticky error, counters.
  int m_mem_cycles = 0;
  bit m_md_busy = 0;
  bit m_err = 0;
  int m_sc = 0;
  int m_fc = 0;

  localparam bit [7:0] MemHold = 8'b1111_0001;
  localparam bit [7:0] MdHold  = 8'b1110_0010;
  localparam bit [7:0] Branch  = 8'b0000_1100;
  localparam bit [7:0] LdUse   = 8'b1100_0100;
  localparam bit [7:0] DropMem = 8'b0000_0010;

  task automatic cyc(input bit r, input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd,
                     input bit mr, input bit pc, input bit ms, input bit md, input bit mq,
                     input bit ma);
    exp_t     e;
    bit       hazard;
    bit [7:0] resolve;
    @(posedge clk);
    #1;
    rst = r; Rs1D = rs1; Rs2D = rs2; RdE = rd; MemReadE = mr; PCSrcE = pc;
    MdStartE = ms; MdDoneE = md; MemReqM = mq; MemAckM = ma;

    hazard  = mr && (rd != 0) && (rd == rs1 || rd == rs2);
    resolve = pc ? Branch : (hazard ? LdUse : 8'b0);
    e.chk_regs = !r;
    e.err = m_err;
    e.sc = m_sc;
    e.fc = m_fc;
    e.ctrl = 8'b0;
    if (r) begin
      m_mem_cycles = 0; m_md_busy = 0; m_err = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (m_mem_cycles > 0) begin
        if (ma) begin
          m_mem_cycles = 0;
        end else if (m_mem_cycles + 1 >= TMO) begin
          e.ctrl = DropMem; m_err = 1; m_mem_cycles = 0;
        end else begin
          e.ctrl = MemHold; m_mem_cycles++;
        end
      end else if (m_md_busy) begin
        if (mq && !ma) e.ctrl = MemHold;
        else if (md) begin e.ctrl = resolve; m_md_busy = 0; end
        else e.ctrl = MdHold;
      end else begin
        if (mq && !ma) begin e.ctrl = MemHold; m_mem_cycles = 1; end
        else if (ms && !md) begin e.ctrl = MdHold; m_md_busy = 1; end
        else e.ctrl = resolve;
      end
      if (e.ctrl[7] && m_sc < CNT_MAX) m_sc++;
      if ((e.ctrl[3] || e.ctrl[2]) && m_fc < CNT_MAX) m_fc++;
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t     e;
    bit [7:0] got;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW};
      checks++;
      if (got !== e.ctrl) begin
        errors++;
        $display("FAIL ctrl @%0t: got %b expected %b", $time, got, e.ctrl);
      end
      if (e.chk_regs) begin
        checks++;
        if (MemErr !== e.err || int'(StallCnt) != e.sc || int'(FlushCnt) != e.fc) begin
          errors++;
          $display("FAIL regs @%0t: got err=%b sc=%0d fc=%0d expected err=%b sc=%0d fc=%0d",
                   $time, MemErr, StallCnt, FlushCnt, e.err, e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);

    // Load-use hit, then x0 never hazards.
    cyc(0, 5, 0, 5, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // Branch overrides load-use.
    cyc(0, 5, 0, 5, 1, 1, 0, 0, 0, 0);
    // Memory wait of 3 cycles then ack.
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    // Same-cycle ack: no stall.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    // Timeout: 3 stalls, drop on the 4th, restart on the 5th.
    repeat (5) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Mul/div 5 stall cycles, branch on done.
    repeat (5) cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    // Reset in the middle of a memory wait.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) < 2),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) < 20),
          ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 30),
          ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 40));
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
